ssd_scan_ctrl: RTL and testbench

- Parametrised, time-multiplexed seven-segment display driver for the board's common-anode digit bank.
- Takes a packed per-digit data bus and a per-digit blank mask and decimal-point mask.
- Each digit slot is decoded either as a hex nibble or as a one-hot switch index, as used by the row/column switch readout.
- Produces registered, tear-free anode, cathode and decimal-point drive, plus a frame strobe, for use by top-level game and debug displays.

---
 rtl/ssd_pkg.sv | 33 +++
 rtl/ssd_decode.sv | 39 +++
 rtl/ssd_scan_ctrl.sv | 135 +++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan driver: decode modes and
// active-low segment patterns, bit order {a,b,c,d,e,f,g}.
package ssd_pkg;

   typedef enum logic {
      MODE_HEX    = 1'b0,
      MODE_ONEHOT = 1'b1
   } mode_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'b1111110;

   // Entry n holds the pattern for hex digit n (element 15 listed first)
   localparam logic [15:0][6:0] HEX_SEG = {
      7'b0111000,  // F
      7'b0110000,  // E
      7'b1000010,  // d
      7'b0110001,  // C
      7'b1100000,  // b
      7'b0001000,  // A
      7'b0000100,  // 9
      7'b0000000,  // 8
      7'b0001111,  // 7
      7'b0100000,  // 6
      7'b0100100,  // 5
      7'b1001100,  // 4
      7'b0000110,  // 3
      7'b0010010,  // 2
      7'b1001111,  // 1
      7'b0000001   // 0
   };

endpackage

// File: rtl/ssd_decode.sv
// Combinational slot decoder: hex nibble or one-hot switch index to segments.
module ssd_decode
   import ssd_pkg::*;
(
   input  logic       mode,
   input  logic [7:0] value,
   output logic [6:0] seg
);

   logic [3:0] ones;
   logic [3:0] pos;

   // Count set bits and remember the set position for one-hot display
   always_comb begin
      ones = '0;
      pos  = '0;
      for (int unsigned b = 0; b < 8; b++) begin
         if (value[b]) begin
            ones = ones + 4'd1;
            pos  = 4'(b);
         end
      end
   end

   // Select the segment pattern for the active decode mode
   always_comb begin
      seg = SEG_BLANK;
      if (mode_e'(mode) == MODE_HEX) begin
         seg = HEX_SEG[value[3:0]];
      end else if (value == 8'h00) begin
         seg = HEX_SEG[0];
      end else if (ones == 4'd1) begin
         seg = HEX_SEG[pos + 4'd1];
      end else begin
         seg = SEG_DASH;
      end
   end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment scan driver with per-frame
// input snapshot, anti-ghost guard, dimming and registered outputs.
module ssd_scan_ctrl
   import ssd_pkg::*;
#(
   parameter int NUM_DIGITS   = 8,
   parameter int SCAN_DIV     = 100000,
   parameter int GUARD_CYCLES = 16,
   parameter int DIG_W        = 8
) (
   input  logic                        clk,
   input  logic                        Reset,
   input  logic                        mode,
   input  logic [NUM_DIGITS*DIG_W-1:0] digits,
   input  logic [NUM_DIGITS-1:0]       blank,
   input  logic [NUM_DIGITS-1:0]       dp_in,
   input  logic                        dim,
   output logic [NUM_DIGITS-1:0]       an,
   output logic [6:0]                  seg,
   output logic                        dp,
   output logic                        frame_done
);

   localparam int CNT_W   = $clog2(SCAN_DIV);
   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int DIM_END = GUARD_CYCLES + (SCAN_DIV - GUARD_CYCLES) / 4;
   localparam int CW      = (DIG_W < 8) ? DIG_W : 8;

   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W:0]   GUARD_V  = (CNT_W + 1)'(GUARD_CYCLES);
   localparam logic [CNT_W:0]   DIM_V    = (CNT_W + 1)'(DIM_END);

   logic [CNT_W-1:0]            div_cnt_q, div_cnt_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic                        frame_done_q, frame_done_d;
   logic [NUM_DIGITS*DIG_W-1:0] snap_digits_q, snap_digits_d;
   logic [NUM_DIGITS-1:0]       snap_blank_q, snap_blank_d;
   logic [NUM_DIGITS-1:0]       snap_dp_q, snap_dp_d;
   logic                        snap_mode_q, snap_mode_d;
   logic                        snap_dim_q, snap_dim_d;
   logic [NUM_DIGITS-1:0]       an_q, an_d;
   logic [6:0]                  seg_q, seg_d;
   logic                        dp_q, dp_d;

   logic                        capture;
   logic [DIG_W-1:0]            digit_sel;
   logic [7:0]                  slot_val;
   logic [6:0]                  dec_seg;
   logic                        an_en;

   // Slot divider and digit index, with end-of-frame strobe
   always_comb begin
      div_cnt_d    = div_cnt_q + 1'b1;
      idx_d        = idx_q;
      frame_done_d = 1'b0;
      if (div_cnt_q == DIV_LAST) begin
         div_cnt_d    = '0;
         idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
         frame_done_d = (idx_q == IDX_LAST);
      end
   end

   // Frame snapshot; the _d values double as the effective shadow so the
   // capture cycle itself already decodes the freshly sampled inputs.
   always_comb begin
      capture       = (div_cnt_q == '0) && (idx_q == '0);
      snap_digits_d = capture ? digits : snap_digits_q;
      snap_blank_d  = capture ? blank  : snap_blank_q;
      snap_dp_d     = capture ? dp_in  : snap_dp_q;
      snap_mode_d   = capture ? mode   : snap_mode_q;
      snap_dim_d    = capture ? dim    : snap_dim_q;
   end

   // Select the current slot, zero-extending narrow digits to 8 bits
   always_comb begin
      digit_sel = snap_digits_d[idx_q*DIG_W +: DIG_W];
      slot_val  = 8'(digit_sel[CW-1:0]);
   end

   ssd_decode u_decode (
      .mode  (snap_mode_d),
      .value (slot_val),
      .seg   (dec_seg)
   );

   // Anode gating (guard, blank, dim window) and output pattern selection
   always_comb begin
      an_en = ({1'b0, div_cnt_q} >= GUARD_V) && !snap_blank_d[idx_q] &&
              (!snap_dim_d || ({1'b0, div_cnt_q} < DIM_V));
      an_d  = '1;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
      if (an_en) begin
         an_d[idx_q] = 1'b0;
         seg_d       = dec_seg;
         dp_d        = ~snap_dp_d[idx_q];
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (Reset) begin
         div_cnt_q     <= '0;
         idx_q         <= '0;
         frame_done_q  <= 1'b0;
         snap_digits_q <= '0;
         snap_blank_q  <= '0;
         snap_dp_q     <= '0;
         snap_mode_q   <= 1'b0;
         snap_dim_q    <= 1'b0;
         an_q          <= '1;
         seg_q         <= SEG_BLANK;
         dp_q          <= 1'b1;
      end else begin
         div_cnt_q     <= div_cnt_d;
         idx_q         <= idx_d;
         frame_done_q  <= frame_done_d;
         snap_digits_q <= snap_digits_d;
         snap_blank_q  <= snap_blank_d;
         snap_dp_q     <= snap_dp_d;
         snap_mode_q   <= snap_mode_d;
         snap_dim_q    <= snap_dim_d;
         an_q          <= an_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with 4 digits, 8-cycle slots, 2-cycle guard.
module tb_ssd_scan_ctrl;

   localparam int ND = 4;
   localparam int SD = 8;
   localparam int GC = 2;
   localparam int DW = 8;
   localparam int DIM_END = 3;   // 2 + (8-2)/4

   logic          clk = 1'b0;
   logic          Reset = 1'b1;
   logic          mode = 1'b0;
   logic          dim = 1'b0;
   logic [31:0]   digits = 32'h030A0900;
   logic [3:0]    blank = 4'b0000;
   logic [3:0]    dp_in = 4'b0000;
   logic [3:0]    an;
   logic [6:0]    seg;
   logic          dp;
   logic          frame_done;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   ssd_scan_ctrl #(
      .NUM_DIGITS   (ND),
      .SCAN_DIV     (SD),
      .GUARD_CYCLES (GC),
      .DIG_W        (DW)
   ) dut (
      .clk        (clk),
      .Reset      (Reset),
      .mode       (mode),
      .digits     (digits),
      .blank      (blank),
      .dp_in      (dp_in),
      .dim        (dim),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s (cyc %0d): got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // Hand-computed slot patterns per frame configuration
   function automatic logic [6:0] exp_seg(input int cfg, input int s);
      case (cfg)
         0, 1: case (s)
                  0: return 7'b0000001;
                  1: return 7'b0000100;
                  2: return 7'b0001000;
                  default: return 7'b0000110;
               endcase
         2: case (s)
                  0: return 7'b1111110;
                  1: return 7'b0000001;
                  2: return 7'b0000110;
                  default: return 7'b0000000;
               endcase
         3: return 7'b1001111;
         default: return 7'b0010010;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_eq({pfx, "_an"}, 32'(an), 32'hF);
      check_eq({pfx, "_seg"}, 32'(seg), 32'h7F);
      check_eq({pfx, "_dp"}, 32'(dp), 32'h1);
      check_eq({pfx, "_fd"}, 32'(frame_done), 32'h0);
   endtask

   // Outputs after edge cyc reflect the counter state of cycle cyc-1
   task automatic check_cycle(input int cfg);
      int c, d, s;
      logic [3:0] bl, dpm;
      logic dm, en;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic e_dp;
      c   = cyc - 1;
      d   = c % SD;
      s   = (c / SD) % ND;
      bl  = (cfg >= 5) ? 4'b0100 : 4'b0000;
      dpm = (cfg >= 5) ? 4'b0001 : 4'b0000;
      dm  = (cfg >= 5);
      en  = (d >= GC) && !bl[s] && (!dm || d < DIM_END);
      e_an  = en ? ~(4'b0001 << s) : 4'hF;
      e_seg = en ? exp_seg(cfg, s) : 7'h7F;
      e_dp  = en ? ~dpm[s] : 1'b1;
      check_eq("an", 32'(an), 32'(e_an));
      check_eq("seg", 32'(seg), 32'(e_seg));
      check_eq("dp", 32'(dp), 32'(e_dp));
      check_eq("frame_done", 32'(frame_done), ((c % (SD*ND)) == SD*ND-1) ? 32'h1 : 32'h0);
   endtask

   initial begin
      // Reset held for three cycles
      Reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_reset_outputs("rst");
      end
      Reset = 1'b0;
      cyc = 0;

      // Frames 0..6 with input changes at chosen mid-frame points
      for (int k = 1; k <= 213; k++) begin
         step();
         check_cycle((cyc - 1) / (SD*ND));
         case (cyc)
            40:  begin mode = 1'b1; digits = 32'h80040005; end
            96:  begin mode = 1'b0; digits = 32'h01010101; end
            114: digits = 32'h02020202;
            140: begin blank = 4'b0100; dp_in = 4'b0001; dim = 1'b1; end
            default: ;
         endcase
      end

      // Counter now at idx 2, div_cnt 5: reset mid-frame
      Reset = 1'b1;
      step();
      check_reset_outputs("midrst");
      Reset = 1'b0;
      cyc = 0;

      // Scanning restarts at digit 0 with the dimmed/blanked configuration
      for (int k = 1; k <= 40; k++) begin
         step();
         check_cycle(5);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
